// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader
//   Parses framed configuration commands arriving byte-by-byte from uart_rx
//   and writes them into a per-channel configuration bank. Each frame is
//   HDR_BYTE, IDX, P0..P(CFG_BYTES-1), CSUM where CSUM is the XOR of IDX and
//   all payload bytes. P0 lands in the lowest byte of the slice. A good frame
//   rewrites exactly one slice and is answered with ACK (8'h06). A bad
//   checksum, an out-of-range index or an inter-byte timeout is answered with
//   NAK (8'h15).
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   _rst         asynchronous active-low reset
//   i_data       received byte
//   i_valid      one-cycle strobe qualifying i_data
//   ch_conf      configuration bank, channel k at [k*CFG_BITS +: CFG_BITS]
//   o_cfg_upd    one-cycle pulse per channel when its slice was rewritten
//   o_ack_data   ACK/NAK byte, stable while o_ack_valid is high
//   o_ack_valid  ACK/NAK byte pending, held until i_ack_ready
//   i_ack_ready  transmit side accepts the pending ACK/NAK byte
//   o_err        one-cycle pulse on checksum, index or timeout error
//   o_overrun    one-cycle pulse for each byte dropped while answering
module cfg_frame_loader #(
  parameter int         CH_NO       = 4,
  parameter int         CFG_BYTES   = 10,
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 43400,
  localparam int        CFG_BITS    = CFG_BYTES * 8
) (
  input  logic                      i_clk,
  input  logic                      _rst,
  input  logic [7:0]                i_data,
  input  logic                      i_valid,
  output logic [CH_NO*CFG_BITS-1:0] ch_conf,
  output logic [CH_NO-1:0]          o_cfg_upd,
  output logic [7:0]                o_ack_data,
  output logic                      o_ack_valid,
  input  logic                      i_ack_ready,
  output logic                      o_err,
  output logic                      o_overrun
);

  localparam int IW = (CH_NO > 1) ? $clog2(CH_NO) : 1;
  localparam int CW = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_INDEX, S_PAYLOAD, S_CHECK, S_COMMIT, S_ACK
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    idx_reg, idx_next;
  logic [7:0]    csum_reg, csum_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    ack_data_reg, ack_data_next;
  logic          ack_valid_reg, ack_valid_next;
  logic          err_reg, err_next;
  logic          overrun_reg, overrun_next;
  logic          stg_clr;
  logic [CFG_BITS-1:0] stg_w;

  logic in_frame, timeout, idx_ok;

  assign in_frame = (state_reg == S_INDEX) || (state_reg == S_PAYLOAD) ||
                    (state_reg == S_CHECK);
  // A byte in the expiry cycle keeps the frame alive.
  assign timeout  = in_frame && !i_valid && (tmo_reg == TW'(TIMEOUT_CYC - 1));
  assign idx_ok   = {1'b0, idx_reg} < 9'(CH_NO);

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      csum_reg      <= '0;
      cnt_reg       <= '0;
      tmo_reg       <= '0;
      ack_data_reg  <= '0;
      ack_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      csum_reg      <= csum_next;
      cnt_reg       <= cnt_next;
      tmo_reg       <= tmo_next;
      ack_data_reg  <= ack_data_next;
      ack_valid_reg <= ack_valid_next;
      err_reg       <= err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    csum_next      = csum_reg;
    cnt_next       = cnt_reg;
    tmo_next       = '0;
    ack_data_next  = ack_data_reg;
    ack_valid_next = ack_valid_reg;
    err_next       = 1'b0;
    overrun_next   = 1'b0;
    stg_clr        = 1'b0;

    if (in_frame && !i_valid) begin
      tmo_next = tmo_reg + TW'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (i_valid && (i_data == HDR_BYTE)) begin
          state_next = S_INDEX;
        end
      end
      S_INDEX: begin
        if (i_valid) begin
          idx_next   = i_data;
          csum_next  = i_data;
          cnt_next   = '0;
          state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (i_valid) begin
          csum_next = csum_reg ^ i_data;
          cnt_next  = cnt_reg + CW'(1);
          if (cnt_reg == CW'(CFG_BYTES - 1)) begin
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (i_valid) begin
          if ((i_data == csum_reg) && idx_ok) begin
            state_next = S_COMMIT;
          end else begin
            err_next      = 1'b1;
            ack_data_next = NAK_BYTE;
            state_next    = S_ACK;
          end
        end
      end
      S_COMMIT: begin
        overrun_next  = i_valid;
        ack_data_next = ACK_BYTE;
        state_next    = S_ACK;
      end
      S_ACK: begin
        overrun_next = i_valid;
        // First ACK cycle raises valid; the handshake can only retire it after.
        if (!ack_valid_reg) begin
          ack_valid_next = 1'b1;
        end else if (i_ack_ready) begin
          ack_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (timeout) begin
      err_next      = 1'b1;
      ack_data_next = NAK_BYTE;
      stg_clr       = 1'b1;
      state_next    = S_ACK;
    end
  end

  // Staging register, one byte lane per payload position.
  genvar gi;
  generate
    for (gi = 0; gi < CFG_BYTES; gi++) begin : g_stg
      logic [7:0] byte_reg;
      always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
          byte_reg <= '0;
        end else if (stg_clr) begin
          byte_reg <= '0;
        end else if ((state_reg == S_PAYLOAD) && i_valid &&
                     (cnt_reg == CW'(gi))) begin
          byte_reg <= i_data;
        end
      end
      assign stg_w[gi*8 +: 8] = byte_reg;
    end

    // Config bank: only the slice addressed by a committed frame is written.
    for (gi = 0; gi < CH_NO; gi++) begin : g_slice
      logic [CFG_BITS-1:0] slice_reg;
      logic                upd_reg;
      logic                sel;
      assign sel = (state_reg == S_COMMIT) && (idx_reg[IW-1:0] == IW'(gi));
      always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
          slice_reg <= '0;
          upd_reg   <= 1'b0;
        end else begin
          upd_reg <= sel;
          if (sel) begin
            slice_reg <= stg_w;
          end
        end
      end
      assign ch_conf[gi*CFG_BITS +: CFG_BITS] = slice_reg;
      assign o_cfg_upd[gi]                    = upd_reg;
    end
  endgenerate

  assign o_ack_data  = ack_data_reg;
  assign o_ack_valid = ack_valid_reg;
  assign o_err       = err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: directed frames, a frame-level reference model
// compared every cycle, and literal expectations for the key results.
module tb_cfg_frame_loader;

  localparam int CH_NO = 4;
  localparam int NB    = 10;
  localparam int TMO   = 40;
  localparam int W     = CH_NO * NB * 8;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_ack_ready = 1'b1;
  logic [W-1:0]  ch_conf;
  logic [CH_NO-1:0] o_cfg_upd;
  logic [7:0]    o_ack_data;
  logic          o_ack_valid, o_err, o_overrun;

  cfg_frame_loader #(.CH_NO(CH_NO), .CFG_BYTES(NB), .HDR_BYTE(8'hA5),
                     .TIMEOUT_CYC(TMO)) dut (
    .i_clk(i_clk), ._rst(rst_n), .i_data(i_data), .i_valid(i_valid),
    .ch_conf(ch_conf), .o_cfg_upd(o_cfg_upd), .o_ack_data(o_ack_data),
    .o_ack_valid(o_ack_valid), .i_ack_ready(i_ack_ready), .o_err(o_err),
    .o_overrun(o_overrun));

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (frame level) ----------------
  int          fpos;          // -1 outside a frame, else index of next frame byte after header
  logic [7:0]  frm [0:NB+1];  // IDX, payload, CSUM
  int          gap;
  bit          busy, good;
  int          since;
  logic [W-1:0]     m_conf;
  logic [CH_NO-1:0] m_upd;
  logic [7:0]  m_ackd;
  bit          m_ackv, m_err, m_ovr;

  task automatic model_reset();
    fpos = -1; gap = 0; busy = 0; good = 0; since = 0;
    m_conf = '0; m_upd = '0; m_ackd = '0; m_ackv = 0; m_err = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    logic [7:0] cs;
    m_err = 0; m_ovr = 0; m_upd = '0;
    if (busy) begin
      if (i_valid) m_ovr = 1;
      since++;
      if (good && since == 1) begin
        for (int i = 0; i < NB; i++) m_conf[int'(frm[0])*NB*8 + i*8 +: 8] = frm[i+1];
        m_upd[frm[0][1:0]] = 1'b1;
        m_ackd = 8'h06;
      end
      if (m_ackv && i_ack_ready) begin
        busy = 0; m_ackv = 0;
      end else if (since == (good ? 2 : 1)) begin
        m_ackv = 1;
      end
    end else if (fpos < 0) begin
      if (i_valid && i_data == 8'hA5) begin fpos = 0; gap = 0; end
    end else if (i_valid) begin
      frm[fpos] = i_data; gap = 0;
      if (fpos == NB + 1) begin
        cs = frm[0];
        for (int i = 1; i <= NB; i++) cs ^= frm[i];
        good = (cs == frm[NB+1]) && (int'(frm[0]) < CH_NO);
        if (!good) begin m_err = 1; m_ackd = 8'h15; end
        busy = 1; since = 0; fpos = -1;
      end else begin
        fpos++;
      end
    end else begin
      gap++;
      if (gap == TMO) begin
        m_err = 1; m_ackd = 8'h15; busy = 1; good = 0; since = 0; fpos = -1;
      end
    end
  endtask

  always @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- compare process and event monitors ----------------
  int ack_cnt = 0, upd_cnt = 0, ovr_cnt = 0, err_cnt = 0;
  logic [7:0]       last_ack = '0;
  logic [CH_NO-1:0] upd_or = '0;

  always @(negedge i_clk) begin
    chk("ch_conf",   ch_conf,     m_conf);
    chk("cfg_upd",   W'(o_cfg_upd),  W'(m_upd));
    chk("ack_data",  W'(o_ack_data), W'(m_ackd));
    chk("ack_valid", W'(o_ack_valid), W'(m_ackv));
    chk("err",       W'(o_err),     W'(m_err));
    chk("overrun",   W'(o_overrun), W'(m_ovr));
    if (o_ack_valid && i_ack_ready) begin ack_cnt++; last_ack = o_ack_data; end
    if (|o_cfg_upd) begin upd_cnt++; upd_or |= o_cfg_upd; end
    if (o_overrun) ovr_cnt++;
    if (o_err) err_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data = b; i_valid = 1'b1;
    tick(1);
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [NB*8-1:0] pl,
                            input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(idx);
    for (int i = 0; i < NB; i++) send_byte(pl[i*8 +: 8]);
    send_byte(cs);
  endtask

  task automatic wait_ack(input string name);
    int start;
    start = ack_cnt;
    for (int i = 0; i < 200 && ack_cnt == start; i++) tick(1);
    chk(name, W'(ack_cnt != start), W'(1));
  endtask

  localparam logic [79:0] PL1 = 80'h1A191817161514131211;
  localparam logic [79:0] PL0 = 80'h07060504030201FF00A5;
  localparam logic [79:0] PL3 = 80'h2A292827262524232221;
  localparam logic [79:0] PL2 = 80'h0102030405060708090A;

  int u0, e0, a0, o0;

  initial begin
    tick(3);
    chk("rst_conf",  ch_conf, '0);
    chk("rst_ackv",  W'(o_ack_valid), W'(0));
    chk("rst_ackd",  W'(o_ack_data), W'(0));
    rst_n = 1'b1;
    tick(2);

    // 1: good frame to channel 1
    send_frame(8'h01, PL1, 8'h0A);
    wait_ack("t1_ack_wait");
    chk("t1_ack", W'(last_ack), W'(8'h06));
    chk("t1_conf", ch_conf, {80'h0, 80'h0, PL1, 80'h0});
    chk("t1_upd_or", W'(upd_or), W'(4'b0010));
    chk("t1_upd_cnt", W'(upd_cnt), W'(1));
    $display("t1 good frame idx1: ack=%02h conf=%0h", last_ack, ch_conf);

    // 2: bad checksum
    u0 = upd_cnt; e0 = err_cnt;
    send_frame(8'h01, PL1, 8'h0B);
    wait_ack("t2_ack_wait");
    chk("t2_ack", W'(last_ack), W'(8'h15));
    chk("t2_err", W'(err_cnt - e0), W'(1));
    chk("t2_upd", W'(upd_cnt - u0), W'(0));
    chk("t2_conf", ch_conf, {80'h0, 80'h0, PL1, 80'h0});
    $display("t2 bad csum: ack=%02h", last_ack);

    // 3: index out of range, then a good frame to channel 3
    send_frame(8'h04, PL1, 8'h0F);
    wait_ack("t3_ack_wait");
    chk("t3_ack", W'(last_ack), W'(8'h15));
    chk("t3_upd", W'(upd_cnt - u0), W'(0));
    send_frame(8'h03, PL3, 8'h08);
    wait_ack("t3b_ack_wait");
    chk("t3b_ack", W'(last_ack), W'(8'h06));
    chk("t3b_conf", ch_conf, {PL3, 80'h0, PL1, 80'h0});
    $display("t3 bad idx then idx3: ack=%02h", last_ack);

    // 4: timeout mid-payload, garbage in idle, good frame (with A5 as data) to channel 0
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    wait_ack("t4_ack_wait");
    chk("t4_ack", W'(last_ack), W'(8'h15));
    chk("t4_err", W'(err_cnt - e0), W'(1));
    send_byte(8'h00); send_byte(8'hFF);
    tick(3);
    send_frame(8'h00, PL0, 8'h5A);
    wait_ack("t4b_ack_wait");
    chk("t4b_ack", W'(last_ack), W'(8'h06));
    chk("t4b_conf", ch_conf, {PL3, 80'h0, PL1, PL0});
    $display("t4 timeout, garbage, idx0: ack=%02h", last_ack);

    // 5: held ACK with overruns, then reset mid-payload
    i_ack_ready = 1'b0; o0 = ovr_cnt;
    send_frame(8'h02, PL2, 8'h09);
    tick(50);
    chk("t5_held", W'(o_ack_valid), W'(1));
    send_byte(8'h55); tick(1); send_byte(8'hA5);
    tick(3);
    chk("t5_ovr", W'(ovr_cnt - o0), W'(2));
    chk("t5_held2", W'(o_ack_valid), W'(1));
    i_ack_ready = 1'b1;
    wait_ack("t5_ack_wait");
    chk("t5_ack", W'(last_ack), W'(8'h06));
    chk("t5_conf", ch_conf, {PL3, PL2, PL1, PL0});
    tick(2);
    chk("t5_idle", W'(o_ack_valid), W'(0));
    $display("t5 held ack: overruns=%0d ack=%02h", ovr_cnt - o0, last_ack);

    a0 = ack_cnt; e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    chk("t6_conf", ch_conf, '0);
    chk("t6_ackd", W'(o_ack_data), W'(0));
    tick(2);
    rst_n = 1'b1;
    tick(60);
    chk("t6_no_ack", W'(ack_cnt - a0), W'(0));
    chk("t6_no_err", W'(err_cnt - e0), W'(0));
    chk("t6_ackv", W'(o_ack_valid), W'(0));
    $display("t6 reset mid-payload: acks=%0d", ack_cnt - a0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
